// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator slice: the controller state
// type, default widths and the burst-length decode helper.
package acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  localparam int PROD_W_D = 8;
  localparam int ACC_W_D  = 16;
  localparam int CNT_W_D  = 4;

  // A length code of zero stands for the largest burst the counter can hold.
  function automatic int unsigned len_decode(input int unsigned len_code,
                                             input int unsigned cnt_w);
    return (len_code == 0) ? (32'd1 << cnt_w) : len_code;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Bundle of the product input handshake and the result output handshake.
// The slave view belongs to the accumulator, the master view to whatever
// drives products in and drains results out.
interface product_accumulator_if
  import acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int CNT_W  = CNT_W_D
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic [CNT_W-1:0]  burst_len;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W:0]    out_count;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_prod, burst_len, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_prod, burst_len, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Accumulator adder: adds a zero-extended product to the running sum and
// reports the carry-out. With SATURATE_EN defined the sum clamps to all ones
// on carry-out; otherwise it wraps.
module sat_adder
  import acc_pkg::*;
#(
  parameter int ACC_W  = ACC_W_D,
  parameter int PROD_W = PROD_W_D
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  // One extra bit of headroom captures the carry-out.
  assign wide  = {1'b0, a} + (ACC_W+1)'(b);
  assign carry = wide[ACC_W];

`ifdef SATURATE_EN
  // Clamp: once the sum pins at all ones, any further nonzero add carries
  // again, so it stays pinned for the rest of the burst.
  assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  // Wrap modulo 2^ACC_W.
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Burst accumulator behind the 4x4 array multiplier. Sums burst_len products
// (0 meaning 2^CNT_W) and hands the total, beat count and sticky overflow out
// on a registered valid/ready port. Overflow handling follows the sat_adder
// build: wrap by default, clamp when SATURATE_EN is defined.
module product_accumulator
  import acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input logic                clk,
  input logic                rst,
  product_accumulator_if.slave bus
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W:0]   cnt;
  logic [CNT_W:0]   len;
  logic             ovf;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W:0]   out_count_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             first_beat;
  logic             beat_take;
  logic             last_beat;
  logic             ovf_next;
  logic [CNT_W:0]   eff_len;
  logic [CNT_W:0]   cnt_inc;

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .a     (acc),
    .b     (bus.in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // The length is taken from the port on the first beat and from the latch
  // afterwards, so mid-burst changes to burst_len are ignored.
  assign first_beat = (cnt == '0);
  assign eff_len    = first_beat ?
                      (CNT_W+1)'(len_decode(32'(bus.burst_len), CNT_W)) : len;
  assign cnt_inc    = cnt + (CNT_W+1)'(1);
  assign beat_take  = (state == ACCUM) && bus.in_valid;
  assign last_beat  = (cnt_inc == eff_len);
  assign ovf_next   = ovf | add_carry;

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  // Controller: accumulate beats in ACCUM, hold the result in DONE until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      len         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat_take) begin
            if (first_beat) len <= eff_len;
            acc <= add_sum;
            cnt <= cnt_inc;
            ovf <= ovf_next;
            if (last_beat) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              out_sum_q   <= add_sum;
              out_count_q <= cnt_inc;
              out_ovf_q   <= ovf_next;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            out_valid_q <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: a 16-bit-accumulator instance for the
// general cases and a 10-bit one for overflow, driven by directed and random
// bursts and checked against a burst-level arithmetic model.
module tb_product_accumulator;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       v16;
  logic       v10;
  logic [7:0] prod;
  logic [3:0] blen;
  logic       ordy;

  int errors = 0;
  int checks = 0;
  int beats[$];

  product_accumulator_if #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) if16 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) if10 ();

  assign if16.in_valid  = v16;
  assign if16.in_prod   = prod;
  assign if16.burst_len = blen;
  assign if16.out_ready = ordy;
  assign if10.in_valid  = v10;
  assign if10.in_prod   = prod;
  assign if10.burst_len = blen;
  assign if10.out_ready = ordy;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut16 (
    .clk (clk), .rst (rst), .bus (if16.slave));
  product_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) dut10 (
    .clk (clk), .rst (rst), .bus (if10.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] getInReady(input bit s);
    return s ? 32'(if10.in_ready) : 32'(if16.in_ready);
  endfunction
  function automatic logic [31:0] getValid(input bit s);
    return s ? 32'(if10.out_valid) : 32'(if16.out_valid);
  endfunction
  function automatic logic [31:0] getSum(input bit s);
    return s ? 32'(if10.out_sum) : 32'(if16.out_sum);
  endfunction
  function automatic logic [31:0] getCount(input bit s);
    return s ? 32'(if10.out_count) : 32'(if16.out_count);
  endfunction
  function automatic logic [31:0] getOvf(input bit s);
    return s ? 32'(if10.out_ovf) : 32'(if16.out_ovf);
  endfunction

  // Reference: the total of the burst, compared against the accumulator range.
  function automatic void modelBurst(input int accw, output int unsigned s,
                                     output int unsigned o);
    int unsigned total = 0;
    int unsigned maxv  = (32'd1 << accw) - 1;
    foreach (beats[i]) total += beats[i];
    o = (total > maxv) ? 1 : 0;
`ifdef SATURATE_EN
    s = (total > maxv) ? maxv : total;
`else
    s = total % (maxv + 1);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setValid(input bit s, input logic v);
    if (s) v10 = v; else v16 = v;
  endtask

  // Drives the queued beats into the selected DUT, with optional idle gaps.
  task automatic applyStimulus(input bit s, input logic [3:0] len_first,
                               input logic [3:0] len_rest, input int max_gap);
    for (int i = 0; i < beats.size(); i++) begin
      int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      setValid(s, 1'b0);
      repeat (gap) begin @(posedge clk); #1; end
      prod = 8'(beats[i]);
      blen = (i == 0) ? len_first : len_rest;
      setValid(s, 1'b1);
      for (int g = 0; g < 40 && getInReady(s) != 1; g++) begin
        @(posedge clk); #1;
      end
      checkOutput("beat_in_ready", getInReady(s), 1);
      @(posedge clk); #1;
    end
    setValid(s, 1'b0);
  endtask

  // Waits (bounded) for a result, checks it, holds it briefly, then takes it.
  task automatic collectResult(input bit s, input string tag,
                               input int unsigned es, input int unsigned ec,
                               input int unsigned eo, input int stall);
    for (int g = 0; g < 40 && getValid(s) != 1; g++) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_valid"}, getValid(s), 1);
    checkOutput({tag, "_sum"}, getSum(s), es);
    checkOutput({tag, "_count"}, getCount(s), ec);
    checkOutput({tag, "_ovf"}, getOvf(s), eo);
    repeat (stall) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_sum"}, getSum(s), es);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    checkOutput({tag, "_taken"}, getValid(s), 0);
  endtask

  initial begin
    int unsigned es, eo;
    rst = 1'b1; v16 = 1'b0; v10 = 1'b0; prod = '0; blen = '0; ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", getInReady(0), 1);
    checkOutput("rst_out_valid", getValid(0), 0);
    checkOutput("rst_out_sum", getSum(0), 0);
    checkOutput("rst_out_count", getCount(0), 0);
    checkOutput("rst_out_ovf", getOvf(0), 0);

    $display("[TB] basic burst");
    ordy = 1'b1;
    beats = '{225, 225, 225, 225};
    applyStimulus(0, 4'd4, 4'd4, 0);
    checkOutput("basic_latency_valid", getValid(0), 1);
    checkOutput("basic_in_ready_low", getInReady(0), 0);
    checkOutput("basic_sum", getSum(0), 900);
    checkOutput("basic_count", getCount(0), 4);
    checkOutput("basic_ovf", getOvf(0), 0);
    @(posedge clk); #1;
    ordy = 1'b0;
    checkOutput("basic_in_ready_back", getInReady(0), 1);
    checkOutput("basic_valid_drop", getValid(0), 0);

    $display("[TB] backpressure");
    beats = '{6, 9};
    applyStimulus(0, 4'd2, 4'd2, 0);
    prod = 8'd50; blen = 4'd1; v16 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", getValid(0), 1);
      checkOutput("bp_sum", getSum(0), 15);
      checkOutput("bp_in_ready", getInReady(0), 0);
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    checkOutput("bp_handoff_valid", getValid(0), 0);
    checkOutput("bp_handoff_in_ready", getInReady(0), 1);
    @(posedge clk); #1;
    v16 = 1'b0;
    checkOutput("bp_next_valid", getValid(0), 1);
    checkOutput("bp_next_sum", getSum(0), 50);
    collectResult(0, "bp_next", 50, 1, 0, 0);

    $display("[TB] zero length encoding");
    beats = {};
    repeat (16) beats.push_back(225);
    applyStimulus(0, 4'd0, 4'd0, 0);
    collectResult(0, "zero", 3600, 16, 0, 1);

    $display("[TB] overflow on 10-bit accumulator");
    beats = '{225, 225, 225, 225, 225};
    modelBurst(10, es, eo);
    applyStimulus(1, 4'd5, 4'd5, 0);
`ifdef SATURATE_EN
    collectResult(1, "ovf", 1023, 5, 1, 2);
`else
    collectResult(1, "ovf", 101, 5, 1, 2);
`endif
    beats = '{1, 1};
    applyStimulus(1, 4'd2, 4'd2, 0);
    collectResult(1, "ovf_next", 2, 2, 0, 0);

    $display("[TB] reset mid-burst");
    beats = '{100, 100};
    applyStimulus(0, 4'd4, 4'd4, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_valid", getValid(0), 0);
    checkOutput("midrst_count", getCount(0), 0);
    beats = '{7};
    applyStimulus(0, 4'd1, 4'd1, 0);
    collectResult(0, "midrst_next", 7, 1, 0, 0);

    $display("[TB] length latch");
    beats = '{1, 2, 3};
    applyStimulus(0, 4'd3, 4'd1, 0);
    collectResult(0, "latch", 6, 3, 0, 0);

    $display("[TB] random bursts");
    for (int b = 0; b < 24; b++) begin
      bit s = 1'($urandom_range(0, 1));
      int n = $urandom_range(1, 16);
      beats = {};
      repeat (n) beats.push_back($urandom_range(0, 255));
      modelBurst(s ? 10 : 16, es, eo);
      applyStimulus(s, 4'(n), 4'($urandom), 1);
      collectResult(s, "rand", es, n, eo, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream stage of the 4x4 array multiplier.
- Consumes the 8-bit products the multiplier emits, one per beat, under a valid/ready handshake.
- Sums a burst of burst_len products into a wide accumulator.
- Presents the burst total with a sticky overflow flag on a registered valid/ready output port.
- Turns the combinational multiplier into a dot-product / multiply-accumulate datapath.

Parameters:
PROD_W, 8, width of each incoming product
ACC_W, 16, accumulator and result width (ACC_W >= PROD_W)
CNT_W, 4, width of burst length and beat counter; max burst = 2^CNT_W

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  accumulator can accept a beat
in_prod  input  PROD_W  unsigned product from multiplier
burst_len  input  CNT_W  beats per burst; 0 encodes 2^CNT_W; sampled on first beat of a burst
out_valid  output  1  burst result valid
out_ready  input  1  consumer accepts result
out_sum  output  ACC_W  accumulated burst total
out_count  output  CNT_W+1  beats summed in the reported burst
out_ovf  output  1  sticky: accumulation exceeded 2^ACC_W-1 during the burst

Behaviour:
- Reset (rst=1 at a clk edge), all registers:
  - state=ACCUM
  - acc=0, beat count=0, latched length=0
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0
  - in_ready=1 in the cycle after reset
- Reset mid-burst discards the partial sum; no result is produced for that burst.
- Handshake rules:
  - A beat transfers when in_valid & in_ready at a clk edge.
  - A result transfers when out_valid & out_ready at a clk edge.
- States:
  - ACCUM: in_ready=1, out_valid=0. Each accepted beat does acc += zero-extended in_prod and count += 1.
    - First accepted beat of a burst (count==0) latches burst_len; len=0 means 2^CNT_W.
    - When the accepted beat makes count equal to the latched length, next state is DONE.
    - out_sum, out_count and out_ovf load from the final acc, count and ovf values.
  - DONE: in_ready=0, out_valid=1, outputs held stable.
    - On out_ready: acc, count and ovf clear; next state is ACCUM.
    - No beat is accepted in the same cycle as the result handoff.
- Latency: result is valid one cycle after the final beat is accepted. Single-beat burst: beat accepted at cycle t, out_valid=1 at t+1.
- Throughput: max one result per (len+1) cycles.
- in_valid while in DONE is ignored; the upstream holds the beat.
- out_valid and out_sum never change while out_valid=1 and out_ready=0.
- Arithmetic: unsigned, ACC_W+1-bit add. Carry-out sets the ovf register (sticky until the burst completes). Default mode wraps acc modulo 2^ACC_W.
- burst_len changes mid-burst have no effect.
- Outputs are registered; there is no combinational path from in_* to out_*.

Optional Feature:
SATURATE_EN
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the burst; out_ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf is set.

Decomposition:
- Shared package acc_pkg holds:
  - state enum (ACCUM, DONE)
  - default width constants PROD_W_D=8, ACC_W_D=16, CNT_W_D=4
  - helper function len_decode (0 -> 2^CNT_W)
- One natural sub-module: sat_adder. An ACC_W adder with carry-out; the saturate path is compiled in under SATURATE_EN. It is instantiated once for the acc update.
- The FSM and counters stay in product_accumulator.

Test Plan:
- Basic burst: burst_len=4, in_prod=225 x4 back-to-back, out_ready=1 -> out_valid one cycle after the 4th beat; out_sum=900 (0x0384), out_count=4, out_ovf=0; in_ready=0 for exactly one cycle.
- Backpressure: burst_len=2, products 6 and 9, out_ready=0 for 5 cycles -> out_sum=15 held stable; in_ready=0 throughout; the next burst's in_valid beat is not accepted until the cycle after out_ready=1.
- Zero encoding: burst_len=0 (CNT_W=4), 16 beats of 225 -> out_sum=3600, out_count=16, out_ovf=0.
- Overflow (ACC_W=10): burst_len=5, 5 x 225 ->
  - without SATURATE_EN: out_sum=101, out_ovf=1
  - with SATURATE_EN: out_sum=1023, out_ovf=1
  - next burst (2 x 1): out_sum=2, out_ovf=0
- Reset mid-burst: burst_len=4, 2 beats of 100, then rst=1 for 1 cycle, then burst_len=1, beat 7 -> no result for the aborted burst; next result out_sum=7, out_count=1.
- Length latch: burst_len=3 on the first beat, changed to 1 after it; beats 1, 2, 3 -> single result out_sum=6, out_count=3.
